// File: rtl/aes32_dec_unit.sv
// aes32_dec_unit: two-stage pipelined execution unit for the scalar AES
// decrypt-direction instructions aes32dsi / aes32dsmi.
//   S1 registers rs1, byte select, mix flag, tag and the inverse S-box output.
//   S2 registers the final rs1 ^ rotl(u, 8*bs) result and its tag.
// Ports:
//   clk, rst (async, active-high), flush (sync kill of in-flight ops)
//   in_valid/in_ready, in_rs1, in_rs2, in_bs, in_mix, in_tag : request side
//   out_valid/out_ready, out_rd, out_tag                       : result side
// Parameters:
//   TAG_W  : width of the opaque tag carried with each op
//   MIX_EN : 0 removes InvMixColumns; every op then executes as dsi
module aes32_dec_unit #(
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned MIX_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [1:0]       in_bs,
  input  logic             in_mix,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rd,
  output logic [TAG_W-1:0] out_tag
);

  // GF(2^8) multiply by x modulo 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) general multiply (shift-and-add)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Inverse S-box: inverse affine transform followed by field inversion
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  logic             s1_valid;
  logic [31:0]      s1_rs1;
  logic [1:0]       s1_bs;
  logic             s1_mix;
  logic [TAG_W-1:0] s1_tag;
  logic [7:0]       s1_s;

  logic             s2_load_c;
  logic             s1_load_c;
  logic             accept_c;
  logic [7:0]       sel_byte_c;
  logic [31:0]      u_c;
  logic [31:0]      rot_c;
  logic [31:0]      rd_c;
  logic             mix_eff_c;

  // Stage advance handshakes
  assign s2_load_c = !out_valid || out_ready;
  assign s1_load_c = !s1_valid || s2_load_c;
  assign in_ready  = s1_load_c;
  assign accept_c  = in_valid && s1_load_c && !flush;

  // Byte select from rs2
  always_comb begin
    sel_byte_c = in_rs2[7:0];
    case (in_bs)
      2'd0: sel_byte_c = in_rs2[7:0];
      2'd1: sel_byte_c = in_rs2[15:8];
      2'd2: sel_byte_c = in_rs2[23:16];
      2'd3: sel_byte_c = in_rs2[31:24];
      default: sel_byte_c = in_rs2[7:0];
    endcase
  end

  // S2 datapath: optional InvMixColumns column, rotate, accumulate
  always_comb begin
    logic [7:0] s2x, s4x, s8x;
    mix_eff_c = (MIX_EN != 0) && s1_mix;
    s2x = xtime(s1_s);
    s4x = xtime(s2x);
    s8x = xtime(s4x);
    if (mix_eff_c)
      u_c = {s8x ^ s2x ^ s1_s, s8x ^ s4x ^ s1_s, s8x ^ s1_s, s8x ^ s4x ^ s2x};
    else
      u_c = {24'h000000, s1_s};
    rot_c = u_c;
    case (s1_bs)
      2'd0: rot_c = u_c;
      2'd1: rot_c = {u_c[23:0], u_c[31:24]};
      2'd2: rot_c = {u_c[15:0], u_c[31:16]};
      2'd3: rot_c = {u_c[7:0],  u_c[31:8]};
      default: rot_c = u_c;
    endcase
    rd_c = s1_rs1 ^ rot_c;
  end

  // Valid bits and reset-carrying output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_rd    <= 32'h0;
      out_tag   <= TAG_W'(0);
    end else begin
      if (s2_load_c) begin
        out_valid <= s1_valid && !flush;
        if (s1_valid) begin
          out_rd  <= rd_c;
          out_tag <= s1_tag;
        end
      end else if (flush) begin
        out_valid <= 1'b0;
      end
      if (s1_load_c || flush) s1_valid <= accept_c;
    end
  end

  // S1 data registers (no reset needed; qualified by s1_valid)
  always_ff @(posedge clk) begin
    if (accept_c) begin
      s1_rs1 <= in_rs1;
      s1_bs  <= in_bs;
      s1_mix <= in_mix;
      s1_tag <= in_tag;
      s1_s   <= inv_sbox(sel_byte_c);
    end
  end

endmodule

// File: tb/tb_aes32_dec_unit.sv
// Self-checking bench for aes32_dec_unit: hand-computed vector table,
// directed pipeline sequences, and a scoreboard driven random run on a
// MIX_EN=1 instance and a MIX_EN=0 instance sharing the same stimulus.
module tb_aes32_dec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_rs1, in_rs2;
  logic [1:0]  in_bs;
  logic        in_mix;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_rd1, out_rd0;
  logic [4:0]  out_tag1, out_tag0;

  always #5 clk = ~clk;

  aes32_dec_unit #(.TAG_W(5), .MIX_EN(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_bs(in_bs), .in_mix(in_mix), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .out_rd(out_rd1), .out_tag(out_tag1)
  );

  aes32_dec_unit #(.TAG_W(5), .MIX_EN(0)) u_nomix (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_bs(in_bs), .in_mix(in_mix), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .out_rd(out_rd0), .out_tag(out_tag0)
  );

  int checks = 0;
  int failures = 0;
  int acc1 = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic [4:0]  tag;
  } res_t;
  res_t q1[$];
  res_t q0[$];

  logic [7:0] inv_tab [256];

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  bs;
    logic        mix;
    logic [31:0] exp1;
    logic [31:0] exp0;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Carry-less product then polynomial reduction by 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  // Inverse S-box table built by inverting the forward S-box, which is
  // derived from a brute-force field inverse
  task automatic build_inv_tab();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xi, b, f;
      xi = 8'h00;
      b  = 8'(x);
      for (int y = 1; y < 256; y++) if (gmul(b, 8'(y)) == 8'h01) xi = 8'(y);
      f = xi ^ rl8(xi, 1) ^ rl8(xi, 2) ^ rl8(xi, 3) ^ rl8(xi, 4) ^ 8'h63;
      inv_tab[f] = b;
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] r1, input logic [31:0] r2,
                                        input logic [1:0] b, input logic m, input logic men);
    logic [7:0]  s;
    logic [31:0] u;
    logic [63:0] d;
    s = inv_tab[r2[8*b +: 8]];
    if (m && men) u = {gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09), gmul(s, 8'h0e)};
    else          u = {24'h0, s};
    d = {u, u} << (8 * b);
    return r1 ^ d[63:32];
  endfunction

  // One cycle: drive at negedge, score outputs and accepts before the posedge
  task automatic step(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [1:0] b, input logic m, input logic [4:0] t,
                      input logic ordy, input logic fl);
    res_t e;
    @(negedge clk);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_bs = b; in_mix = m; in_tag = t;
    out_ready = ordy; flush = fl;
    #1;
    if (out_valid1 && out_ready) begin
      if (q1.size() == 0) chk("spurious_valid_mix", 32'(out_valid1), 32'd0);
      else begin
        e = q1.pop_front();
        chk("rd_mix", out_rd1, e.rd);
        chk("tag_mix", 32'(out_tag1), 32'(e.tag));
      end
    end
    if (out_valid0 && out_ready) begin
      if (q0.size() == 0) chk("spurious_valid_nomix", 32'(out_valid0), 32'd0);
      else begin
        e = q0.pop_front();
        chk("rd_nomix", out_rd0, e.rd);
        chk("tag_nomix", 32'(out_tag0), 32'(e.tag));
      end
    end
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (v && in_ready1) begin
        q1.push_back('{rd: model(r1, r2, b, m, 1'b1), tag: t});
        acc1++;
      end
      if (v && in_ready0) q0.push_back('{rd: model(r1, r2, b, m, 1'b0), tag: t});
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q1.size() != 0 || q0.size() != 0); i++) idle(1'b1);
    chk("drain_empty_mix", 32'(q1.size()), 32'd0);
    chk("drain_empty_nomix", 32'(q0.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] hold;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0;
    in_bs = '0; in_mix = 1'b0; in_tag = '0; out_ready = 1'b1;

    vecs[0] = '{32'h0,        32'h0,        2'd0, 1'b0, 32'h00000052, 32'h00000052};
    vecs[1] = '{32'h0,        32'h0,        2'd2, 1'b0, 32'h00520000, 32'h00520000};
    vecs[2] = '{32'h0,        32'h63000000, 2'd3, 1'b0, 32'h00000000, 32'h00000000};
    vecs[3] = '{32'h0,        32'h0,        2'd0, 1'b1, 32'h50a7f451, 32'h00000052};
    vecs[4] = '{32'h0,        32'h0,        2'd1, 1'b1, 32'ha7f45150, 32'h00005200};
    vecs[5] = '{32'hffffffff, 32'h0,        2'd0, 1'b1, 32'haf580bae, 32'hffffffad};
    vecs[6] = '{32'h12345678, 32'h0,        2'd1, 1'b0, 32'h12340478, 32'h12340478};

    build_inv_tab();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_out_rd", out_rd1, 32'h0);
    chk("rst_out_tag", 32'(out_tag1), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready1), 32'd1);

    // Hand-computed vectors, one at a time
    for (int k = 0; k < 7; k++) begin
      step(1'b1, vecs[k].rs1, vecs[k].rs2, vecs[k].bs, vecs[k].mix, 5'(k), 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      chk("vec_valid", 32'(out_valid1), 32'd1);
      chk("vec_rd_mix", out_rd1, vecs[k].exp1);
      chk("vec_rd_nomix", out_rd0, vecs[k].exp0);
      chk("vec_tag", 32'(out_tag1), 32'(k));
    end
    drain();

    // 8 back-to-back ops: results on consecutive cycles, 2 cycles after drive
    for (int k = 0; k < 10; k++) begin
      if (k < 8) step(1'b1, 32'h01010101 * k, 32'h11223344 + k, 2'(k), 1'(k & 1), 5'(k + 8), 1'b1, 1'b0);
      else       idle(1'b1);
      chk("b2b_valid", 32'(out_valid1), (k >= 2) ? 32'd1 : 32'd0);
    end
    drain();

    // Backpressure: two accepts then stall, stable output, ordered release
    acc1 = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 32'hcafe0000 + k, 32'h5a5a5a5a + k, 2'(k), 1'b1, 5'(k + 20), 1'b0, 1'b0);
      if (k == 2) begin
        chk("bp_valid", 32'(out_valid1), 32'd1);
        hold = out_rd1;
      end else if (k > 2) begin
        chk("bp_stable", out_rd1, hold);
      end
    end
    chk("bp_accepts", 32'(acc1), 32'd2);
    chk("bp_in_ready", 32'(in_ready1), 32'd0);
    step(1'b1, 32'hbeef0000, 32'h0f0f0f0f, 2'd1, 1'b1, 5'd30, 1'b1, 1'b0);
    chk("bp_third_accept", 32'(acc1), 32'd3);
    drain();

    // Flush with both stages full
    step(1'b1, 32'h1, 32'h2, 2'd0, 1'b1, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'h3, 32'h4, 2'd1, 1'b1, 5'd2, 1'b0, 1'b0);
    step(1'b1, 32'h5, 32'h6, 2'd2, 1'b1, 5'd3, 1'b0, 1'b1);
    idle(1'b1);
    chk("flush_valid", 32'(out_valid1), 32'd0);
    repeat (4) idle(1'b1);
    step(1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("flush_next_rd", out_rd1, 32'h00000052);
    drain();

    // Async reset with two ops in flight
    step(1'b1, 32'h7, 32'h8, 2'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    step(1'b1, 32'h9, 32'ha, 2'd3, 1'b1, 5'd6, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid1), 32'd0);
    chk("arst_rd", out_rd1, 32'h0);
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready1), 32'd1);
    step(1'b1, 32'h0, 32'h0, 2'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("arst_fresh_rd", out_rd1, 32'h50a7f451);
    drain();

    // Random traffic with backpressure and occasional flush
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
